// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: IV, round constants, FSM states and the UNROLL legality check.
package sha1_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_CALC,
    ST_FINAL,
    ST_OUT
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
  } work_t;

  localparam work_t SHA1_IV = work_t'(160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0);

  localparam logic [31:0] K0 = 32'h5A827999;
  localparam logic [31:0] K1 = 32'h6ED9EBA1;
  localparam logic [31:0] K2 = 32'h8F1BBCDC;
  localparam logic [31:0] K3 = 32'hCA62C1D6;

  function automatic logic [31:0] k_const(input logic [6:0] idx);
    if (idx < 7'd20)      return K0;
    else if (idx < 7'd40) return K1;
    else if (idx < 7'd60) return K2;
    else                  return K3;
  endfunction

  // UNROLL must divide 80 and stay within the 16-word schedule window.
  function automatic bit unroll_ok(input int u);
    return (u == 1) || (u == 2) || (u == 4) || (u == 5) ||
           (u == 8) || (u == 10) || (u == 16);
  endfunction

endpackage

// File: rtl/sha1_round_unit.sv
// One combinational SHA-1 round; function and constant are chosen from the absolute round index.
module sha1_round_unit
  import sha1_pkg::*;
(
  input  logic [6:0]  idx,
  input  work_t       state_in,
  input  logic [31:0] w,
  output work_t       state_out
);

  logic [31:0] f;
  logic [31:0] temp;

  always_comb begin
    f = state_in.b ^ state_in.c ^ state_in.d;
    if (idx < 7'd20) begin
      f = (state_in.b & state_in.c) | (~state_in.b & state_in.d);
    end else if (idx >= 7'd40 && idx < 7'd60) begin
      f = (state_in.b & state_in.c) | (state_in.b & state_in.d) | (state_in.c & state_in.d);
    end
  end

  assign temp = {state_in.a[26:0], state_in.a[31:27]} + f + state_in.e + k_const(idx) + w;

  assign state_out = '{a: temp,
                       b: state_in.a,
                       c: {state_in.b[1:0], state_in.b[31:2]},
                       d: state_in.c,
                       e: state_in.d};

endmodule

// File: rtl/sha1_core_par.sv
// SHA-1 block core with UNROLL rounds per clock; 16-word load, 80/UNROLL calc cycles, one add cycle.
module sha1_core_par
  import sha1_pkg::*;
#(
  parameter int UNROLL  = 1,
  parameter bit OUT_REG = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [159:0] digest,
  output logic         busy
);

  if (!unroll_ok(UNROLL)) begin : g_bad_unroll
    $error("sha1_core_par: UNROLL must be one of 1,2,4,5,8,10,16");
  end

  state_t             state, state_nxt;
  logic [3:0]         word_cnt;
  logic [6:0]         rnd_cnt;
  logic [15:0][31:0]  w_reg;
  logic               first_l, last_l;
  work_t              work, work_next, cv, base, sum;
  logic               accept, calc_done;

  assign accept    = in_valid && (state == ST_LOAD);
  assign calc_done = (rnd_cnt == 7'(80 - UNROLL));
  assign base      = first_l ? SHA1_IV : cv;

  assign sum = '{a: cv.a + work.a,
                 b: cv.b + work.b,
                 c: cv.c + work.c,
                 d: cv.d + work.d,
                 e: cv.e + work.e};

  // Window holds W[t..t+15]; produce UNROLL new words, later ones may reuse earlier new ones.
  function automatic logic [15:0][31:0] sched_next(input logic [15:0][31:0] w);
    logic [31:0][31:0] ext;
    logic [31:0]       x;
    ext       = '0;
    ext[15:0] = w;
    for (int j = 0; j < UNROLL; j++) begin
      x           = ext[j+13] ^ ext[j+8] ^ ext[j+2] ^ ext[j];
      ext[j+16]   = {x[30:0], x[31]};
    end
    return ext[UNROLL +: 16];
  endfunction

  for (genvar k = 0; k < UNROLL; k++) begin : g_rnd
    work_t stage_in, stage_out;
    if (k == 0) begin : g_head
      assign stage_in = work;
    end else begin : g_link
      assign stage_in = g_rnd[k-1].stage_out;
    end
    sha1_round_unit u_round (
      .idx       (rnd_cnt + 7'(k)),
      .state_in  (stage_in),
      .w         (w_reg[k]),
      .state_out (stage_out)
    );
  end
  assign work_next = g_rnd[UNROLL-1].stage_out;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD:  if (accept && word_cnt == 4'd15) state_nxt = ST_CALC;
        ST_CALC:  if (calc_done) state_nxt = ST_FINAL;
        ST_FINAL: state_nxt = last_l ? ST_OUT : ST_LOAD;
        ST_OUT:   if (out_ready) state_nxt = ST_LOAD;
        default:  state_nxt = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_LOAD;
      word_cnt <= '0;
      rnd_cnt  <= '0;
      w_reg    <= '0;
      first_l  <= 1'b0;
      last_l   <= 1'b0;
      work     <= '0;
      cv       <= SHA1_IV;
    end else begin
      state <= state_nxt;
      if (abort) begin
        word_cnt <= '0;
        rnd_cnt  <= '0;
        cv       <= SHA1_IV;
      end else begin
        case (state)
          ST_LOAD: begin
            if (accept) begin
              w_reg    <= {in_data, w_reg[15:1]};
              word_cnt <= word_cnt + 4'd1;
              if (word_cnt == 4'd0) begin
                first_l <= in_first;
                last_l  <= in_last;
              end
              if (word_cnt == 4'd15) begin
                cv      <= base;
                work    <= base;
                rnd_cnt <= '0;
              end
            end
          end
          ST_CALC: begin
            work    <= work_next;
            w_reg   <= sched_next(w_reg);
            rnd_cnt <= rnd_cnt + 7'(UNROLL);
          end
          ST_FINAL: begin
            cv      <= sum;
            rnd_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [159:0] dig_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dig_reg <= '0;
      end else if (!abort && state == ST_FINAL && last_l) begin
        dig_reg <= sum;
      end
    end
    assign digest = dig_reg;
  end else begin : g_out_comb
    // The chaining value register holds the adder result for the whole OUT phase.
    assign digest = (state == ST_OUT) ? cv : '0;
  end

  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_LOAD);

endmodule
